// File: rtl/lcd_bus_receiver.sv
// rtl/lcd_bus_receiver.sv - 8080-style LCD write bus receiver with CASET/PASET window tracking and RGB565 pixel assembly
module lcd_bus_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_lcd_data,
  input  logic        i_lcd_rs,
  input  logic        i_lcd_wr,
  input  logic        i_lcd_cs_n,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd,
  output logic        o_pixel_valid,
  output logic [15:0] o_pixel_data,
  output logic [8:0]  o_pixel_x,
  output logic [8:0]  o_pixel_y,
  output logic        o_frame_start
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] rs_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   wr_prev;
  logic                   cs_prev;

  logic       wr_s;
  logic       cs_s;
  logic       rs_s;
  logic [7:0] data_s;
  logic       strobe;
  logic       cs_rise;

  state_t     state;
  logic [8:0] xs, xe, ys, ye;
  logic [8:0] x, y;
  logic       phase;
  logic [2:0] pidx;
  logic [7:0] hi_byte;

  assign wr_s    = wr_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign rs_s    = rs_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign strobe  = wr_s & ~wr_prev & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev;

  // Synchronize the asynchronous bus; idle levels on reset so no false strobe or deselect appears
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_sync <= '1;
      cs_sync <= '1;
      rs_sync <= '1;
      wr_prev <= 1'b1;
      cs_prev <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= 8'h00;
    end else begin
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], i_lcd_wr};
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], i_lcd_cs_n};
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], i_lcd_rs};
      wr_prev <= wr_s;
      cs_prev <= cs_s;
      data_sync[0] <= i_lcd_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  // Decode strobed bytes: command dispatch, window parameters and pixel assembly
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      xs            <= 9'd0;
      xe            <= 9'd239;
      ys            <= 9'd0;
      ye            <= 9'd319;
      x             <= 9'd0;
      y             <= 9'd0;
      phase         <= 1'b0;
      pidx          <= 3'd0;
      hi_byte       <= 8'h00;
      o_cmd_valid   <= 1'b0;
      o_cmd         <= 8'h00;
      o_pixel_valid <= 1'b0;
      o_pixel_data  <= 16'h0000;
      o_pixel_x     <= 9'd0;
      o_pixel_y     <= 9'd0;
      o_frame_start <= 1'b0;
    end else begin
      o_cmd_valid   <= 1'b0;
      o_pixel_valid <= 1'b0;
      o_frame_start <= 1'b0;
      if (strobe) begin
        if (!rs_s) begin
          o_cmd_valid <= 1'b1;
          o_cmd       <= data_s;
          pidx        <= 3'd0;
          phase       <= 1'b0;
          case (data_s)
            8'h2A: state <= S_CASET;
            8'h2B: state <= S_PASET;
            8'h2C: begin
              state         <= S_RAMWR;
              x             <= xs;
              y             <= ys;
              o_frame_start <= 1'b1;
            end
            8'h3C: state <= S_RAMWR;
            default: state <= S_IGNORE;
          endcase
        end else begin
          case (state)
            S_CASET, S_PASET: begin
              if (pidx != 3'd4) begin
                pidx <= pidx + 3'd1;
                if (state == S_CASET) begin
                  case (pidx[1:0])
                    2'd0: xs[8]   <= data_s[0];
                    2'd1: xs[7:0] <= data_s;
                    2'd2: xe[8]   <= data_s[0];
                    default: xe[7:0] <= data_s;
                  endcase
                end else begin
                  case (pidx[1:0])
                    2'd0: ys[8]   <= data_s[0];
                    2'd1: ys[7:0] <= data_s;
                    2'd2: ye[8]   <= data_s[0];
                    default: ye[7:0] <= data_s;
                  endcase
                end
              end
            end
            S_RAMWR: begin
              if (!phase) begin
                hi_byte <= data_s;
                phase   <= 1'b1;
              end else begin
                phase         <= 1'b0;
                o_pixel_valid <= 1'b1;
                o_pixel_data  <= {hi_byte, data_s};
                o_pixel_x     <= x;
                o_pixel_y     <= y;
                if (x == xe) begin
                  x <= xs;
                  y <= (y == ye) ? ys : y + 9'd1;
                end else begin
                  x <= x + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end else if (cs_rise) begin
        phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// tb/tb_lcd_bus_receiver.sv - directed self-checking bench for lcd_bus_receiver
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  lcd_data = 8'h00;
  logic        lcd_rs = 1'b1;
  logic        lcd_wr = 1'b1;
  logic        lcd_cs_n = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd;
  logic        pixel_valid;
  logic [15:0] pixel_data;
  logic [8:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_start;

  int checks = 0;
  int failures = 0;
  int n_cmd = 0;
  int n_fs = 0;
  int n_fs_orphan = 0;
  int n_wide = 0;
  logic prev_pulse = 1'b0;
  logic [33:0] pix_q [$];

  lcd_bus_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_lcd_data    (lcd_data),
    .i_lcd_rs      (lcd_rs),
    .i_lcd_wr      (lcd_wr),
    .i_lcd_cs_n    (lcd_cs_n),
    .o_cmd_valid   (cmd_valid),
    .o_cmd         (cmd),
    .o_pixel_valid (pixel_valid),
    .o_pixel_data  (pixel_data),
    .o_pixel_x     (pixel_x),
    .o_pixel_y     (pixel_y),
    .o_frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Record every output pulse seen on the falling edge
  always @(negedge clk) begin
    if (pixel_valid) pix_q.push_back({pixel_data, pixel_x, pixel_y});
    if (cmd_valid) n_cmd++;
    if (frame_start) n_fs++;
    if (frame_start && !cmd_valid) n_fs_orphan++;
    if (prev_pulse && (pixel_valid || cmd_valid)) n_wide++;
    prev_pulse = pixel_valid | cmd_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input int idx, input int d, input int px, input int py);
    if (idx >= pix_q.size()) begin
      checks++;
      failures++;
      $error("FAIL %s missing pixel index=%0d observed_count=%0d", tag, idx, pix_q.size());
    end else begin
      check({tag, "_data"}, 32'(pix_q[idx][33:18]), d);
      check({tag, "_x"}, 32'(pix_q[idx][17:9]), px);
      check({tag, "_y"}, 32'(pix_q[idx][8:0]), py);
    end
  endtask

  // Minimum-width write: 3 cycles low, 3 cycles high, data held into the high phase
  task automatic wb(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_data = d;
    lcd_wr = 1'b0;
    repeat (3) @(negedge clk);
    lcd_wr = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pix(input logic [15:0] d);
    wb(1'b1, d[15:8]);
    wb(1'b1, d[7:0]);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int fs0;
    int cmd0;
    int bad;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd", 32'(cmd), 0);
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    check("rst_pixel_data", 32'(pixel_data), 0);
    check("rst_pixel_xy", 32'({pixel_x, pixel_y}), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_no_pulses", 32'(n_cmd + pix_q.size()), 0);

    // Latency: pulse appears two edges after the first edge that samples wr high
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_data = 8'h2C;
    lcd_wr = 1'b0;
    repeat (3) @(negedge clk);
    lcd_wr = 1'b1;
    @(negedge clk);
    check("lat_e0", 32'(cmd_valid), 0);
    @(negedge clk);
    check("lat_e1", 32'(cmd_valid), 0);
    @(negedge clk);
    check("lat_e2_cmd_valid", 32'(cmd_valid), 1);
    check("lat_e2_frame_start", 32'(frame_start), 1);
    check("lat_e2_cmd", 32'(cmd), 32'h2C);
    @(negedge clk);
    check("lat_width_cmd_valid", 32'(cmd_valid), 0);
    check("lat_width_frame_start", 32'(frame_start), 0);
    pix(16'hF800);
    settle();
    check("first_count", pix_q.size(), 1);
    check_pix("first_pix", 0, 16'hF800, 0, 0);
    check("hold_data", 32'(pixel_data), 32'hF800);

    // Default window row wrap
    pix_q.delete();
    wb(1'b0, 8'h2C);
    for (int i = 0; i < 241; i++) pix(16'(i));
    settle();
    check("row_count", pix_q.size(), 241);
    check_pix("row_last", 239, 239, 239, 0);
    check_pix("row_next", 240, 240, 0, 1);
    bad = 0;
    for (int i = 0; i < pix_q.size(); i++)
      if (pix_q[i][33:18] !== 16'(i)) bad++;
    check("row_data_seq", bad, 0);

    // 0x3C continues from the current position without frame_start
    pix_q.delete();
    fs0 = n_fs;
    wb(1'b0, 8'h2C);
    pix(16'h0001);
    pix(16'h0002);
    pix(16'h0003);
    wb(1'b0, 8'h3C);
    pix(16'h0004);
    settle();
    check("cont_fs", n_fs - fs0, 1);
    check_pix("cont_pix", 3, 4, 3, 0);

    // Unknown command with a parameter only reports the command
    pix_q.delete();
    cmd0 = n_cmd;
    wb(1'b0, 8'h36);
    wb(1'b1, 8'h08);
    settle();
    check("ign_cmd", 32'(cmd), 32'h36);
    check("ign_cmd_count", n_cmd - cmd0, 1);
    check("ign_no_pix", pix_q.size(), 0);
    wb(1'b0, 8'h3C);
    pix(16'h0005);
    settle();
    check_pix("ign_after", 0, 5, 4, 0);

    // Small window
    pix_q.delete();
    wb(1'b0, 8'h2A); wb(1'b1, 8'h00); wb(1'b1, 8'h02); wb(1'b1, 8'h00); wb(1'b1, 8'h03);
    wb(1'b0, 8'h2B); wb(1'b1, 8'h00); wb(1'b1, 8'h05); wb(1'b1, 8'h00); wb(1'b1, 8'h06);
    wb(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) pix(16'(16'hA000 + i));
    settle();
    check("win_count", pix_q.size(), 5);
    check_pix("win_p0", 0, 16'hA000, 2, 5);
    check_pix("win_p1", 1, 16'hA001, 3, 5);
    check_pix("win_p2", 2, 16'hA002, 2, 6);
    check_pix("win_p3", 3, 16'hA003, 3, 6);
    check_pix("win_p4", 4, 16'hA004, 2, 5);

    // CASET during RAMWR leaves the current position alone
    pix_q.delete();
    wb(1'b0, 8'h2A); wb(1'b1, 8'h00); wb(1'b1, 8'h10); wb(1'b1, 8'h00); wb(1'b1, 8'h20);
    wb(1'b0, 8'h3C);
    pix(16'h1111);
    settle();
    check_pix("mid_caset", 0, 16'h1111, 3, 5);

    // xs > xe wraps through 511; high-byte bits 7:1 dropped; extra params ignored
    pix_q.delete();
    wb(1'b0, 8'h2A); wb(1'b1, 8'hFF); wb(1'b1, 8'hFE); wb(1'b1, 8'hFE); wb(1'b1, 8'h01);
    wb(1'b1, 8'h77);
    wb(1'b0, 8'h2B); wb(1'b1, 8'h00); wb(1'b1, 8'h00); wb(1'b1, 8'h00); wb(1'b1, 8'h00);
    wb(1'b0, 8'h2C);
    for (int i = 0; i < 5; i++) pix(16'(16'hB000 + i));
    settle();
    check("wrap_count", pix_q.size(), 5);
    check_pix("wrap_p0", 0, 16'hB000, 510, 0);
    check_pix("wrap_p1", 1, 16'hB001, 511, 0);
    check_pix("wrap_p2", 2, 16'hB002, 0, 0);
    check_pix("wrap_p3", 3, 16'hB003, 1, 0);
    check_pix("wrap_p4", 4, 16'hB004, 510, 0);

    // Deselect discards a half pixel
    pix_q.delete();
    wb(1'b0, 8'h2C);
    wb(1'b1, 8'hAB);
    @(negedge clk);
    lcd_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    lcd_cs_n = 1'b0;
    repeat (5) @(negedge clk);
    pix(16'h1234);
    settle();
    check("cs_count", pix_q.size(), 1);
    check_pix("cs_pix", 0, 16'h1234, 510, 0);

    // Reset between the two bytes of a pixel
    pix_q.delete();
    wb(1'b0, 8'h2C);
    wb(1'b1, 8'h55);
    cmd0 = n_cmd;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_pix", pix_q.size(), 0);
    check("rstmid_no_cmd", n_cmd - cmd0, 0);
    check("rstmid_cmd_reg", 32'(cmd), 0);
    wb(1'b0, 8'h2C);
    wb(1'b1, 8'h07);
    wb(1'b1, 8'hE0);
    settle();
    check("rstmid_count", pix_q.size(), 1);
    check_pix("rstmid_pix", 0, 16'h07E0, 0, 0);

    check("fs_with_cmd", n_fs_orphan, 0);
    check("pulse_width", n_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
